// File: rtl/rob.sv
// Reorder buffer: in-order allocate, out-of-order writeback completion, in-order retire.
// Define ROB_FLUSH_EN to add the flush port.
module rob #(
   parameter int FETCH_WIDTH  = 2,
   parameter int COMMIT_WIDTH = 2,
   parameter int WB_PORTS     = 2,
   parameter int ROB_DEPTH    = 16,
   parameter int CTL_W        = 8,
   localparam int TAG_W       = $clog2(ROB_DEPTH)
) (
   input  logic                            clk,
   input  logic                            resetn,
`ifdef ROB_FLUSH_EN
   input  logic                            flush,
`endif
   input  logic [FETCH_WIDTH-1:0]          in_valid,
   input  logic [5*FETCH_WIDTH-1:0]        in_dst,
   input  logic [64*FETCH_WIDTH-1:0]       in_pc,
   input  logic [CTL_W*FETCH_WIDTH-1:0]    in_ctl,
   output logic                            in_ready,
   output logic [TAG_W*FETCH_WIDTH-1:0]    psrc,
   input  logic [WB_PORTS-1:0]             wb_valid,
   input  logic [TAG_W*WB_PORTS-1:0]       wb_preg,
   input  logic [64*WB_PORTS-1:0]          wb_data,
   output logic [COMMIT_WIDTH-1:0]         retire_valid,
   output logic [64*COMMIT_WIDTH-1:0]      retire_data,
   output logic [CTL_W*COMMIT_WIDTH-1:0]   retire_ctl,
   output logic [5*COMMIT_WIDTH-1:0]       retire_dst,
   output logic [TAG_W*COMMIT_WIDTH-1:0]   retire_preg
);

   logic [TAG_W:0]          headPtr, tailPtr, count, allocN, retN;
   logic [ROB_DEPTH-1:0]    entValid, entDone;
   logic [4:0]              entDst [ROB_DEPTH];
   logic [CTL_W-1:0]        entCtl [ROB_DEPTH];
   logic [63:0]             entData [ROB_DEPTH];
   // pc is kept per entry for trace/debug; no retire port carries it
   logic [63:0]             unusedEntPc [ROB_DEPTH];
   logic [TAG_W-1:0]        allocIdx [FETCH_WIDTH];
   logic [TAG_W-1:0]        retIdx [COMMIT_WIDTH];
   logic [TAG_W-1:0]        wbIdx [WB_PORTS];
   logic [COMMIT_WIDTH-1:0] retSel;
   logic                    inReady;

   assign count    = tailPtr - headPtr;
   // No credit for entries retiring this cycle: readiness uses the pre-edge count
   assign inReady  = (count <= (TAG_W+1)'(ROB_DEPTH - FETCH_WIDTH));
   assign in_ready = inReady;

   always_comb begin
      allocN = '0;
      psrc   = '0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         allocIdx[i]              = tailPtr[TAG_W-1:0] + TAG_W'(i);
         psrc[i*TAG_W +: TAG_W]   = allocIdx[i];
         allocN                   = allocN + (TAG_W+1)'(in_valid[i]);
      end
   end

   always_comb begin
      for (int k = 0; k < WB_PORTS; k++) begin
         wbIdx[k] = wb_preg[k*TAG_W +: TAG_W];
      end
   end

   // The first entry that is not both valid and done blocks every younger lane
   always_comb begin
      logic blocked;
      blocked = 1'b0;
      retSel  = '0;
      retN    = '0;
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
         retIdx[j] = headPtr[TAG_W-1:0] + TAG_W'(j);
         if (!blocked && entValid[retIdx[j]] && entDone[retIdx[j]]) begin
            retSel[j] = 1'b1;
            retN      = retN + (TAG_W+1)'(1);
         end else begin
            blocked = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         headPtr      <= '0;
         tailPtr      <= '0;
         entValid     <= '0;
         entDone      <= '0;
         retire_valid <= '0;
         retire_data  <= '0;
         retire_ctl   <= '0;
         retire_dst   <= '0;
         retire_preg  <= '0;
      end
`ifdef ROB_FLUSH_EN
      else if (flush) begin
         headPtr      <= '0;
         tailPtr      <= '0;
         entValid     <= '0;
         entDone      <= '0;
         retire_valid <= '0;
      end
`endif
      else begin
         for (int k = 0; k < WB_PORTS; k++) begin
            if (wb_valid[k] && entValid[wbIdx[k]]) entDone[wbIdx[k]] <= 1'b1;
         end
         for (int j = 0; j < COMMIT_WIDTH; j++) begin
            if (retSel[j]) begin
               entValid[retIdx[j]]                <= 1'b0;
               entDone[retIdx[j]]                 <= 1'b0;
               retire_data[j*64 +: 64]            <= entData[retIdx[j]];
               retire_ctl[j*CTL_W +: CTL_W]       <= entCtl[retIdx[j]];
               retire_dst[j*5 +: 5]               <= entDst[retIdx[j]];
               retire_preg[j*TAG_W +: TAG_W]      <= retIdx[j];
            end
         end
         if (inReady) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
               if (in_valid[i]) begin
                  entValid[allocIdx[i]] <= 1'b1;
                  entDone[allocIdx[i]]  <= 1'b0;
               end
            end
            tailPtr <= tailPtr + allocN;
         end
         headPtr      <= headPtr + retN;
         retire_valid <= retSel;
      end
   end

   // Payload storage; loop order makes the highest writeback port win on a tag collision
   always_ff @(posedge clk) begin
      for (int k = 0; k < WB_PORTS; k++) begin
         if (wb_valid[k] && entValid[wbIdx[k]]) entData[wbIdx[k]] <= wb_data[k*64 +: 64];
      end
      if (inReady) begin
         for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (in_valid[i]) begin
               entDst[allocIdx[i]]      <= in_dst[i*5 +: 5];
               entCtl[allocIdx[i]]      <= in_ctl[i*CTL_W +: CTL_W];
               unusedEntPc[allocIdx[i]] <= in_pc[i*64 +: 64];
            end
         end
      end
   end

endmodule

// File: tb/tb_rob.sv
// Directed self-checking bench for rob (flush scenario built when ROB_FLUSH_EN is defined).
module tb_rob;
   logic         clk = 1'b0;
   logic         resetn;
`ifdef ROB_FLUSH_EN
   logic         flush;
`endif
   logic [1:0]   in_valid;
   logic [9:0]   in_dst;
   logic [127:0] in_pc;
   logic [15:0]  in_ctl;
   logic         in_ready;
   logic [7:0]   psrc;
   logic [1:0]   wb_valid;
   logic [7:0]   wb_preg;
   logic [127:0] wb_data;
   logic [1:0]   retire_valid;
   logic [127:0] retire_data;
   logic [15:0]  retire_ctl;
   logic [9:0]   retire_dst;
   logic [7:0]   retire_preg;

   int checks = 0;
   int errors = 0;

   rob #(.FETCH_WIDTH(2), .COMMIT_WIDTH(2), .WB_PORTS(2), .ROB_DEPTH(16), .CTL_W(8)) dut (
      .clk(clk),
      .resetn(resetn),
`ifdef ROB_FLUSH_EN
      .flush(flush),
`endif
      .in_valid(in_valid),
      .in_dst(in_dst),
      .in_pc(in_pc),
      .in_ctl(in_ctl),
      .in_ready(in_ready),
      .psrc(psrc),
      .wb_valid(wb_valid),
      .wb_preg(wb_preg),
      .wb_data(wb_data),
      .retire_valid(retire_valid),
      .retire_data(retire_data),
      .retire_ctl(retire_ctl),
      .retire_dst(retire_dst),
      .retire_preg(retire_preg)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs();
      in_valid = '0;
      in_dst   = '0;
      in_pc    = '0;
      in_ctl   = '0;
      wb_valid = '0;
      wb_preg  = '0;
      wb_data  = '0;
`ifdef ROB_FLUSH_EN
      flush    = 1'b0;
`endif
   endtask

   task automatic doReset();
      idleInputs();
      resetn = 1'b0;
      step();
      step();
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      idleInputs();
      resetn = 1'b0;
      step();
      checks++; if (retire_valid !== 2'b00) begin errors++; $display("FAIL reset_rv: got %0h expected 0", retire_valid); end
      checks++; if (retire_preg !== 8'h00) begin errors++; $display("FAIL reset_preg: got %0h expected 0", retire_preg); end
      checks++; if (retire_dst !== 10'h000) begin errors++; $display("FAIL reset_dst: got %0h expected 0", retire_dst); end
      checks++; if (retire_data !== 128'h0) begin errors++; $display("FAIL reset_data: got %0h expected 0", retire_data); end
      checks++; if (psrc !== 8'h10) begin errors++; $display("FAIL reset_psrc: got %0h expected 10", psrc); end
      step();
      resetn = 1'b1;
      step();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", in_ready); end
   endtask

   task automatic test_basic();
      in_valid = 2'b11; in_dst = {5'd2, 5'd1}; in_ctl = {8'hB2, 8'hB1}; in_pc = {64'h1004, 64'h1000};
      #1;
      checks++; if (psrc !== 8'h10) begin errors++; $display("FAIL basic_psrc: got %0h expected 10", psrc); end
      step();
      idleInputs();
      wb_valid = 2'b11; wb_preg = {4'd1, 4'd0}; wb_data = {64'hBBBB, 64'hAAAA};
      checks++; if (retire_valid !== 2'b00) begin errors++; $display("FAIL basic_rv_early: got %0h expected 0", retire_valid); end
      step();
      idleInputs();
      checks++; if (retire_valid !== 2'b00) begin errors++; $display("FAIL basic_rv_n1: got %0h expected 0", retire_valid); end
      step();
      checks++; if (retire_valid !== 2'b11) begin errors++; $display("FAIL basic_rv: got %0h expected 3", retire_valid); end
      checks++; if (retire_dst !== {5'd2, 5'd1}) begin errors++; $display("FAIL basic_dst: got %0h expected %0h", retire_dst, {5'd2, 5'd1}); end
      checks++; if (retire_preg !== 8'h10) begin errors++; $display("FAIL basic_preg: got %0h expected 10", retire_preg); end
      checks++; if (retire_data !== {64'hBBBB, 64'hAAAA}) begin errors++; $display("FAIL basic_data: got %0h", retire_data); end
      checks++; if (retire_ctl !== 16'hB2B1) begin errors++; $display("FAIL basic_ctl: got %0h expected b2b1", retire_ctl); end
      step();
      checks++; if (retire_valid !== 2'b00) begin errors++; $display("FAIL basic_rv_once: got %0h expected 0", retire_valid); end
      checks++; if (psrc !== 8'h32) begin errors++; $display("FAIL basic_psrc_next: got %0h expected 32", psrc); end
   endtask

   task automatic test_out_of_order();
      doReset();
      in_valid = 2'b11; in_dst = {5'd11, 5'd10}; step();
      in_valid = 2'b11; in_dst = {5'd13, 5'd12}; step();
      idleInputs();
      wb_valid = 2'b01; wb_preg = {4'd0, 4'd3}; wb_data = {64'h0, 64'h33}; step(); idleInputs();
      checks++; if (retire_valid !== 2'b00) begin errors++; $display("FAIL ooo_wb3: got %0h expected 0", retire_valid); end
      wb_valid = 2'b01; wb_preg = {4'd0, 4'd2}; wb_data = {64'h0, 64'h22}; step(); idleInputs();
      checks++; if (retire_valid !== 2'b00) begin errors++; $display("FAIL ooo_wb2: got %0h expected 0", retire_valid); end
      wb_valid = 2'b01; wb_preg = {4'd0, 4'd0}; wb_data = {64'h0, 64'h10}; step(); idleInputs();
      checks++; if (retire_valid !== 2'b00) begin errors++; $display("FAIL ooo_wb0: got %0h expected 0", retire_valid); end
      // both ports hit tag 1; port 1 data must land
      wb_valid = 2'b11; wb_preg = {4'd1, 4'd1}; wb_data = {64'h11, 64'hDEAD}; step(); idleInputs();
      checks++; if (retire_valid !== 2'b01) begin errors++; $display("FAIL ooo_ret0_rv: got %0h expected 1", retire_valid); end
      checks++; if (retire_preg[3:0] !== 4'd0) begin errors++; $display("FAIL ooo_ret0_preg: got %0h expected 0", retire_preg[3:0]); end
      checks++; if (retire_dst[4:0] !== 5'd10) begin errors++; $display("FAIL ooo_ret0_dst: got %0d expected 10", retire_dst[4:0]); end
      checks++; if (retire_data[63:0] !== 64'h10) begin errors++; $display("FAIL ooo_ret0_data: got %0h expected 10", retire_data[63:0]); end
      step();
      checks++; if (retire_valid !== 2'b11) begin errors++; $display("FAIL ooo_ret12_rv: got %0h expected 3", retire_valid); end
      checks++; if (retire_preg !== 8'h21) begin errors++; $display("FAIL ooo_ret12_preg: got %0h expected 21", retire_preg); end
      checks++; if (retire_data !== {64'h22, 64'h11}) begin errors++; $display("FAIL ooo_ret12_data: got %0h", retire_data); end
      step();
      checks++; if (retire_valid !== 2'b01) begin errors++; $display("FAIL ooo_ret3_rv: got %0h expected 1", retire_valid); end
      checks++; if (retire_preg[3:0] !== 4'd3) begin errors++; $display("FAIL ooo_ret3_preg: got %0h expected 3", retire_preg[3:0]); end
      checks++; if (retire_dst[4:0] !== 5'd13) begin errors++; $display("FAIL ooo_ret3_dst: got %0d expected 13", retire_dst[4:0]); end
      checks++; if (retire_data[63:0] !== 64'h33) begin errors++; $display("FAIL ooo_ret3_data: got %0h expected 33", retire_data[63:0]); end
      step();
      checks++; if (retire_valid !== 2'b00) begin errors++; $display("FAIL ooo_idle: got %0h expected 0", retire_valid); end
   endtask

   task automatic test_fill();
      int got;
      doReset();
      for (int p = 0; p < 8; p++) begin
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d: got %0b expected 1", p, in_ready); end
         in_valid = 2'b11; in_dst = {5'(2*p+2), 5'(2*p+1)};
         step();
      end
      idleInputs();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full: got %0b expected 0", in_ready); end
      checks++; if (psrc !== 8'h10) begin errors++; $display("FAIL fill_psrc: got %0h expected 10", psrc); end
      for (int c = 0; c < 2; c++) begin
         in_valid = 2'b11; in_dst = {5'd31, 5'd31};
         step();
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_hold_ready: got %0b expected 0", in_ready); end
         checks++; if (psrc !== 8'h10) begin errors++; $display("FAIL fill_hold_psrc: got %0h expected 10", psrc); end
      end
      idleInputs();
      got = 0;
      for (int c = 0; c < 14; c++) begin
         idleInputs();
         if (c < 8) begin
            wb_valid = 2'b11; wb_preg = {4'(2*c+1), 4'(2*c)};
            wb_data = {64'h500 + 64'(2*c+1), 64'h500 + 64'(2*c)};
         end
         step();
         for (int j = 0; j < 2; j++) begin
            if (retire_valid[j]) begin
               checks++; if (retire_preg[j*4 +: 4] !== 4'(got)) begin errors++; $display("FAIL fill_preg: got %0d expected %0d", retire_preg[j*4 +: 4], got); end
               checks++; if (retire_dst[j*5 +: 5] !== 5'(got+1)) begin errors++; $display("FAIL fill_dst: got %0d expected %0d", retire_dst[j*5 +: 5], got+1); end
               checks++; if (retire_data[j*64 +: 64] !== 64'h500 + 64'(got)) begin errors++; $display("FAIL fill_data: got %0h expected %0h", retire_data[j*64 +: 64], 64'h500 + 64'(got)); end
               got++;
            end
         end
      end
      checks++; if (got != 16) begin errors++; $display("FAIL fill_count: got %0d expected 16", got); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_drained: got %0b expected 1", in_ready); end
   endtask

   task automatic test_wrap();
      int nAlloc, nRet, pendK;
      logic pend;
      doReset();
      nAlloc = 0; nRet = 0; pendK = 0; pend = 1'b0;
      for (int cyc = 0; cyc < 80 && nRet < 40; cyc++) begin
         idleInputs();
         if (pend) begin
            wb_valid = 2'b11; wb_preg = {4'((pendK+1)%16), 4'(pendK%16)};
            wb_data = {64'hC000 + 64'(pendK+1), 64'hC000 + 64'(pendK)};
         end
         pend = 1'b0;
         if (nAlloc < 40) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready: got %0b expected 1", in_ready); end
            checks++; if (psrc !== {4'((nAlloc+1)%16), 4'(nAlloc%16)}) begin errors++; $display("FAIL wrap_psrc: got %0h at alloc %0d", psrc, nAlloc); end
            in_valid = 2'b11; in_dst = {5'(nAlloc+1), 5'(nAlloc)}; in_ctl = {8'(nAlloc+1), 8'(nAlloc)};
            pend = 1'b1; pendK = nAlloc; nAlloc += 2;
         end
         step();
         for (int j = 0; j < 2; j++) begin
            if (retire_valid[j]) begin
               checks++; if (retire_preg[j*4 +: 4] !== 4'(nRet%16)) begin errors++; $display("FAIL wrap_preg: got %0d expected %0d", retire_preg[j*4 +: 4], nRet%16); end
               checks++; if (retire_dst[j*5 +: 5] !== 5'(nRet)) begin errors++; $display("FAIL wrap_dst: got %0d expected %0d", retire_dst[j*5 +: 5], 5'(nRet)); end
               checks++; if (retire_ctl[j*8 +: 8] !== 8'(nRet)) begin errors++; $display("FAIL wrap_ctl: got %0d expected %0d", retire_ctl[j*8 +: 8], nRet); end
               checks++; if (retire_data[j*64 +: 64] !== 64'hC000 + 64'(nRet)) begin errors++; $display("FAIL wrap_data: got %0h expected %0h", retire_data[j*64 +: 64], 64'hC000 + 64'(nRet)); end
               nRet++;
            end
         end
      end
      idleInputs();
      checks++; if (nRet != 40) begin errors++; $display("FAIL wrap_total: got %0d expected 40", nRet); end
   endtask

   task automatic test_simultaneous();
      doReset();
      for (int p = 0; p < 7; p++) begin
         in_valid = 2'b11; in_dst = {5'(2*p+1), 5'(2*p)};
         step();
      end
      idleInputs();
      wb_valid = 2'b11; wb_preg = {4'd1, 4'd0}; wb_data = {64'h101, 64'h100};
      step();
      idleInputs();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL simul_ready14: got %0b expected 1", in_ready); end
      checks++; if (psrc !== 8'hFE) begin errors++; $display("FAIL simul_psrc14: got %0h expected fe", psrc); end
      in_valid = 2'b11; in_dst = {5'd21, 5'd20};
      step();
      idleInputs();
      checks++; if (retire_valid !== 2'b11) begin errors++; $display("FAIL simul_rv: got %0h expected 3", retire_valid); end
      checks++; if (retire_preg !== 8'h10) begin errors++; $display("FAIL simul_preg: got %0h expected 10", retire_preg); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL simul_ready: got %0b expected 1", in_ready); end
      checks++; if (psrc !== 8'h10) begin errors++; $display("FAIL simul_psrc: got %0h expected 10", psrc); end
      in_valid = 2'b11; in_dst = {5'd23, 5'd22};
      step();
      idleInputs();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL simul_full: got %0b expected 0", in_ready); end
      checks++; if (retire_valid !== 2'b00) begin errors++; $display("FAIL simul_noret: got %0h expected 0", retire_valid); end
   endtask

`ifdef ROB_FLUSH_EN
   task automatic test_flush();
      doReset();
      in_valid = 2'b11; step();
      in_valid = 2'b11; step();
      in_valid = 2'b01; step();
      idleInputs();
      wb_valid = 2'b01; wb_preg = {4'd0, 4'd0}; wb_data = {64'h0, 64'h77};
      step();
      idleInputs();
      flush = 1'b1;
      step();
      flush = 1'b0;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %0b expected 1", in_ready); end
      checks++; if (psrc !== 8'h10) begin errors++; $display("FAIL flush_psrc: got %0h expected 10", psrc); end
      checks++; if (retire_valid !== 2'b00) begin errors++; $display("FAIL flush_rv: got %0h expected 0", retire_valid); end
      wb_valid = 2'b11; wb_preg = {4'd4, 4'd3}; wb_data = {64'h44, 64'h33};
      step();
      idleInputs();
      step();
      checks++; if (retire_valid !== 2'b00) begin errors++; $display("FAIL flush_late_wb: got %0h expected 0", retire_valid); end
      step();
      checks++; if (retire_valid !== 2'b00) begin errors++; $display("FAIL flush_late_wb2: got %0h expected 0", retire_valid); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_out_of_order();
      test_fill();
      test_wrap();
      test_simultaneous();
`ifdef ROB_FLUSH_EN
      test_flush();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/rob.md
# rob

Reorder buffer between rename and retire. Accepts up to FETCH_WIDTH renamed instructions per cycle, gives each a physical tag (its ROB slot index) returned to rename as psrc, and marks entries complete from writeback. Retires up to COMMIT_WIDTH completed instructions per cycle in program order to the RAT.

## Interface
- FETCH_WIDTH, 2, allocation lanes per cycle
- COMMIT_WIDTH, 2, retire lanes per cycle
- WB_PORTS, 2, writeback completion ports
- ROB_DEPTH, 16, entries; power of two, ≥ 2·max(FETCH_WIDTH, COMMIT_WIDTH)
- CTL_W, width of control_t
- clk  in  1  clock
- resetn  in  1  reset; asynchronous, active-low
- in_valid  in  FETCH_WIDTH  per-lane allocate request (rename_intf instr.valid)
- in_dst  in  5·FETCH_WIDTH  creg destination per lane
- in_pc  in  64·FETCH_WIDTH  pc per lane
- in_ctl  in  CTL_W·FETCH_WIDTH  control per lane
- in_ready  out  1  at least FETCH_WIDTH free entries
- psrc  out  log2(ROB_DEPTH)·FETCH_WIDTH  tag for lane i = (tail + i) mod ROB_DEPTH
- wb_valid  in  WB_PORTS  completion strobe
- wb_preg  in  log2(ROB_DEPTH)·WB_PORTS  completed tag
- wb_data  in  64·WB_PORTS  result
- retire_valid  out  COMMIT_WIDTH  retire_intf retire.valid
- retire_data  out  64·COMMIT_WIDTH  result
- retire_ctl  out  CTL_W·COMMIT_WIDTH  control
- retire_dst  out  5·COMMIT_WIDTH  creg destination
- retire_preg  out  log2(ROB_DEPTH)·COMMIT_WIDTH  tag being freed
- flush  in  1  only with ROB_FLUSH_EN

## Operation
- Storage: per entry valid, done, dst, pc, ctl, data. Head/tail pointers carry one extra wrap bit; count = tail − head (log2(ROB_DEPTH)+1 bits, modular).
- Allocate: in_valid must be contiguous from lane 0; non-contiguous patterns are illegal. If in_ready, lane i with in_valid writes entry tail+i (valid=1, done=0); tail advances by popcount(in_valid). If !in_ready, nothing is written and tail holds; rename must stall.
- psrc is combinational from tail; valid regardless of in_valid.
- Writeback: wb_valid[k] sets done=1 and data=wb_data[k] at entry wb_preg[k] if that entry is valid; otherwise ignored. Two ports hitting the same tag in one cycle: higher k wins.
- Retire select (combinational on registered state): lane j is eligible if entries head..head+j are all valid and done. First non-done/invalid entry blocks all younger lanes. Selected entries are copied into retire output registers, cleared (valid=0), and head advances by the count, at the same edge.
- ctl/pc are stored as given; no decoding.

## Timing
- Reset (resetn low, asynchronous): head=tail=0, all valid/done=0, retire_valid=0, retire_data/ctl/dst/preg=0; in_ready=1 after release.
- Alloc → entry visible to writeback next cycle. Writeback in cycle N → eligible for retire selection in N+1 → retire_valid high in N+2 (registered output, held exactly one cycle per retirement).
- Writeback to an entry in the same cycle it is allocated is illegal.
- Alloc and retire in the same cycle: count = count + alloc − retire; in_ready is computed from the pre-edge count (no same-cycle credit for retiring entries).
- Full: count = ROB_DEPTH → in_ready=0; ROB_DEPTH−FETCH_WIDTH < count → in_ready=0. Empty: no retire.
- Pointer wrap: indices taken modulo ROB_DEPTH; wrap bit distinguishes full from empty.

## Configuration
- ROB_FLUSH_EN defined: flush port present. flush high at an edge clears all valid/done, sets head=tail=0, retire_valid=0 next cycle; flush takes priority over allocate, writeback and retire in that cycle.
- Not defined: no flush port; entries leave only by retire.

## Test plan
- Reset then in_valid=2'b11 with dst 1,2 → psrc 0,1; wb tags 0,1 next cycle → retire_valid=2'b11 two cycles later, dst 1,2, preg 0,1.
- Out-of-order completion: allocate tags 0..3, wb tag 3 then 2 → no retire; wb tag 0 → retire tag 0 only; wb tag 1 → retire 1,2 then 3 in the next cycle.
- Fill: allocate 8 pairs without writeback → count=16, in_ready=0; further in_valid ignored, tail unchanged.
- Wrap: steady allocate/complete/retire for 40 instructions → tags sequence 0..15,0..; retire order equals allocation order, no drop.
- Simultaneous: count=14, retire 2 and allocate 2 same cycle → count stays 14, in_ready=1 next cycle evaluated from 14.
- ROB_FLUSH_EN: 5 entries live, flush → next cycle in_ready=1, psrc lane 0 = 0, late wb to old tag ignored, no retire.
